boot_load_sequencer: RTL

- Loads a program image from a byte-stream host link into CPU memory while holding the CPU in reset.
- Verifies the image checksum, then hands memory back to the core and releases the CPU.
- Sits between the host link and stage7 top level: drives CtrlRst and the PC/MSP/RSP register resets, and owns memory port 1 through a loader-select mux.

---
 rtl/boot_load_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/boot_load_sequencer.sv
// Boot loader: streams a length-prefixed, checksummed image from a byte link into
// memory port 1 while holding the CPU in reset, then hands memory back and releases it.
module boot_load_sequencer #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          MAX_WORDS  = 1024,
  parameter int          RESET_HOLD = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  byteIn_i,
  input  logic        byteValid_i,
  output logic        byteReady_o,
  output logic        ldWrite_o,
  output logic [15:0] ldAddr_o,
  output logic [15:0] ldData_o,
  output logic        memSel_o,
  output logic        cpuRst_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] wordCount_o
);

  localparam int HW = $clog2(RESET_HOLD + 1) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD);
  localparam logic [15:0]   MAX_LEN   = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CSUM, RELEASE, RUN, ERR
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [7:0]    hiByte_q, hiByte_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   csum_q, csum_d;
  logic [15:0]   wordCount_q, wordCount_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ldWrite_q, ldWrite_d;
  logic [15:0]   ldAddr_q, ldAddr_d;
  logic [15:0]   ldData_q, ldData_d;
  logic          memSel_q, memSel_d;
  logic          cpuRst_q, cpuRst_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic        byteReady;
  logic        xfer;
  logic        wordDone;
  logic [15:0] word;

  assign byteReady = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign xfer      = byteValid_i && byteReady;
  assign wordDone  = xfer && phase_q;
  assign word      = {hiByte_q, byteIn_i};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hiByte_d    = hiByte_q;
    len_d       = len_q;
    csum_d      = csum_q;
    wordCount_d = wordCount_q;
    hold_d      = hold_q;
    ldWrite_d   = 1'b0;
    ldAddr_d    = ldAddr_q;
    ldData_d    = ldData_q;

    if (xfer) begin
      phase_d = ~phase_q;
      if (!phase_q) hiByte_d = byteIn_i;
    end

    case (state_q)
      IDLE, RUN, ERR: begin
        if (start_i) begin
          state_d     = LEN;
          wordCount_d = '0;
          csum_d      = '0;
          phase_d     = 1'b0;
          hold_d      = '0;
        end
      end
      LEN: begin
        if (wordDone) begin
          len_d = word;
          if (word > MAX_LEN)    state_d = ERR;
          else if (word == '0)   state_d = CSUM;
          else                   state_d = DATA;
        end
      end
      DATA: begin
        // The write is registered, so the final word moves us to CSUM while it is still in flight.
        if (wordDone) begin
          ldWrite_d   = 1'b1;
          ldAddr_d    = BASE_ADDR + wordCount_q;
          ldData_d    = word;
          wordCount_d = wordCount_q + 16'd1;
          csum_d      = csum_q + word;
          if (wordCount_q + 16'd1 == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (wordDone) begin
          hold_d  = '0;
          state_d = (word == csum_q) ? RELEASE : ERR;
        end
      end
      RELEASE: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    memSel_d = !((state_d == RELEASE) || (state_d == RUN));
    cpuRst_d = (state_d != RUN);
    done_d   = (state_d == RUN);
    error_d  = (state_d == ERR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hiByte_q    <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      wordCount_q <= '0;
      hold_q      <= '0;
      ldWrite_q   <= 1'b0;
      ldAddr_q    <= BASE_ADDR;
      ldData_q    <= '0;
      memSel_q    <= 1'b1;
      cpuRst_q    <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hiByte_q    <= hiByte_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      wordCount_q <= wordCount_d;
      hold_q      <= hold_d;
      ldWrite_q   <= ldWrite_d;
      ldAddr_q    <= ldAddr_d;
      ldData_q    <= ldData_d;
      memSel_q    <= memSel_d;
      cpuRst_q    <= cpuRst_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign byteReady_o = byteReady;
  assign ldWrite_o   = ldWrite_q;
  assign ldAddr_o    = ldAddr_q;
  assign ldData_o    = ldData_q;
  assign memSel_o    = memSel_q;
  assign cpuRst_o    = cpuRst_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign wordCount_o = wordCount_q;

endmodule
